// File: rtl/tablero_pkg.sv
// Shared types for the 2048 move engine.
//  N       board side (lines per board, tiles per line)
//  TILE_W  tile value width; value 0 marks an empty cell
//  Flattened board layout on ports: cell [row][col] occupies
//  bits [(row*N+col)*TILE_W +: TILE_W].
//  Optional build macro MOVER_FIN_JUEGO_EN adds the CHEQ state.
package tablero_pkg;

  localparam int N      = 4;
  localparam int TILE_W = 32;
  localparam int IDX_W  = $clog2(N);
  localparam int CMP_W  = $clog2(N + 1);

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t linea_t [N];
  typedef tile_t tablero_t [N][N];

  typedef enum logic [1:0] {
    IZQ = 2'b00,
    DER = 2'b01,
    ARR = 2'b10,
    ABA = 2'b11
  } dir_e;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
`ifdef MOVER_FIN_JUEGO_EN
    CHEQ,
`endif
    FIN
  } estado_e;

endpackage

// File: rtl/mover_linea.sv
// Combinational single-line 2048 move.
//  linea_in      line, element 0 nearest the move target
//  linea_out     compacted and merged line, zero-filled toward element N-1
//  puntos_linea  sum of merged tile values in this line
//  cambio        1 if linea_out differs from linea_in
module mover_linea
  import tablero_pkg::*;
(
  input  linea_t linea_in,
  output linea_t linea_out,
  output tile_t  puntos_linea,
  output logic   cambio
);

  // Merged value wraps at TILE_W bits.
  function automatic tile_t fusionar(input tile_t a, input tile_t b);
    return a + b;
  endfunction

  // comp carries one extra zero slot so the last element has a
  // neighbour to compare against.
  tile_t comp   [N+1];
  tile_t valor  [N];
  logic  conserv [N];
  int    pos;
  logic  saltar;

  always_comb begin
    for (int k = 0; k <= N; k++) comp[CMP_W'(k)] = '0;
    for (int k = 0; k < N; k++) begin
      valor[IDX_W'(k)]     = '0;
      conserv[IDX_W'(k)]   = 1'b0;
      linea_out[IDX_W'(k)] = '0;
    end
    puntos_linea = '0;
    cambio       = 1'b0;
    saltar       = 1'b0;
    pos          = 0;

    // Compact non-zero tiles toward element 0.
    for (int i = 0; i < N; i++) begin
      if (linea_in[IDX_W'(i)] != '0) begin
        for (int k = 0; k < N; k++)
          if (pos == k) comp[CMP_W'(k)] = linea_in[IDX_W'(i)];
        pos++;
      end
    end

    // Merge scanning from element 0; the second tile of a pair is
    // consumed, so no tile takes part in two merges.
    for (int i = 0; i < N; i++) begin
      if (saltar) begin
        saltar = 1'b0;
      end else if (comp[CMP_W'(i)] != '0) begin
        conserv[IDX_W'(i)] = 1'b1;
        if (comp[CMP_W'(i)] == comp[CMP_W'(i + 1)]) begin
          valor[IDX_W'(i)] = fusionar(comp[CMP_W'(i)], comp[CMP_W'(i + 1)]);
          puntos_linea     = puntos_linea + valor[IDX_W'(i)];
          saltar           = 1'b1;
        end else begin
          valor[IDX_W'(i)] = comp[CMP_W'(i)];
        end
      end
    end

    // Repack surviving tiles contiguously from element 0.
    pos = 0;
    for (int i = 0; i < N; i++) begin
      if (conserv[IDX_W'(i)]) begin
        for (int k = 0; k < N; k++)
          if (pos == k) linea_out[IDX_W'(k)] = valor[IDX_W'(i)];
        pos++;
      end
    end

    for (int i = 0; i < N; i++)
      if (linea_out[IDX_W'(i)] != linea_in[IDX_W'(i)]) cambio = 1'b1;
  end

endmodule

// File: rtl/mover_tablero.sv
// Sequential 2048 move engine: one board line per cycle through a
// shared mover_linea slice.
//  clk, rst           clock, synchronous active-high reset
//  start, direccion   move request and direction (00 L, 01 R, 10 U, 11 D)
//  matriz_entrada     input board, captured with start
//  busy, done         busy during processing; done pulses when results valid
//  matriz_resultante  moved board, movido change flag, puntos merge score
//  sin_movimientos    only with MOVER_FIN_JUEGO_EN: no move possible on result
module mover_tablero
  import tablero_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [1:0]              direccion,
  input  logic [N*N*TILE_W-1:0]   matriz_entrada,
  output logic                    busy,
  output logic                    done,
  output logic [N*N*TILE_W-1:0]   matriz_resultante,
  output logic                    movido,
  output logic [TILE_W-1:0]       puntos
`ifdef MOVER_FIN_JUEGO_EN
  ,
  output logic                    sin_movimientos
`endif
);

  estado_e           state_q, state_d;
  dir_e              dir_q;
  logic [IDX_W-1:0]  idx_q;
  logic              captura;
  tablero_t          tab_q, entrada;
  linea_t            linea_in, linea_out;
  tile_t             puntos_linea;
  logic              cambio;

  mover_linea u_linea (
    .linea_in     (linea_in),
    .linea_out    (linea_out),
    .puntos_linea (puntos_linea),
    .cambio       (cambio)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A start in FIN is accepted so moves can run back to back.
  always_comb begin
    state_d = state_q;
    captura = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        captura = 1'b1;
        state_d = PROC;
      end
      PROC: begin
        busy = 1'b1;
        if (idx_q == IDX_W'(N - 1)) begin
`ifdef MOVER_FIN_JUEGO_EN
          state_d = CHEQ;
`else
          state_d = FIN;
`endif
        end
      end
`ifdef MOVER_FIN_JUEGO_EN
      CHEQ: begin
        busy    = 1'b1;
        state_d = FIN;
      end
`endif
      FIN: begin
        done = 1'b1;
        if (start) begin
          captura = 1'b1;
          state_d = PROC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        entrada[IDX_W'(r)][IDX_W'(c)] = matriz_entrada[(r*N + c)*TILE_W +: TILE_W];
  end

  // Element 0 of the extracted line is the cell nearest the move target.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      linea_in[IDX_W'(c)] = '0;
      case (dir_q)
        IZQ: linea_in[IDX_W'(c)] = tab_q[idx_q][IDX_W'(c)];
        DER: linea_in[IDX_W'(c)] = tab_q[idx_q][IDX_W'(N - 1 - c)];
        ARR: linea_in[IDX_W'(c)] = tab_q[IDX_W'(c)][idx_q];
        ABA: linea_in[IDX_W'(c)] = tab_q[IDX_W'(N - 1 - c)][idx_q];
        default: linea_in[IDX_W'(c)] = '0;
      endcase
    end
  end

  // The working board doubles as the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      tab_q  <= '{default: '0};
      dir_q  <= IZQ;
      idx_q  <= '0;
      puntos <= '0;
      movido <= 1'b0;
    end else if (captura) begin
      tab_q  <= entrada;
      dir_q  <= dir_e'(direccion);
      idx_q  <= '0;
      puntos <= '0;
      movido <= 1'b0;
    end else if (state_q == PROC) begin
      for (int c = 0; c < N; c++) begin
        case (dir_q)
          IZQ: tab_q[idx_q][IDX_W'(c)]         <= linea_out[IDX_W'(c)];
          DER: tab_q[idx_q][IDX_W'(N - 1 - c)] <= linea_out[IDX_W'(c)];
          ARR: tab_q[IDX_W'(c)][idx_q]         <= linea_out[IDX_W'(c)];
          ABA: tab_q[IDX_W'(N - 1 - c)][idx_q] <= linea_out[IDX_W'(c)];
          default: ;
        endcase
      end
      idx_q  <= idx_q + 1'b1;
      puntos <= puntos + puntos_linea;
      movido <= movido | cambio;
    end
  end

  always_comb begin
    matriz_resultante = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        matriz_resultante[(r*N + c)*TILE_W +: TILE_W] = tab_q[IDX_W'(r)][IDX_W'(c)];
  end

`ifdef MOVER_FIN_JUEGO_EN
  // Stuck board: full, with no equal orthogonal neighbours.
  logic bloqueado;
  always_comb begin
    bloqueado = 1'b1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        if (tab_q[IDX_W'(r)][IDX_W'(c)] == '0) bloqueado = 1'b0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N - 1; c++)
        if (tab_q[IDX_W'(r)][IDX_W'(c)] == tab_q[IDX_W'(r)][IDX_W'(c + 1)]) bloqueado = 1'b0;
    for (int r = 0; r < N - 1; r++)
      for (int c = 0; c < N; c++)
        if (tab_q[IDX_W'(r)][IDX_W'(c)] == tab_q[IDX_W'(r + 1)][IDX_W'(c)]) bloqueado = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst || captura)       sin_movimientos <= 1'b0;
    else if (state_q == CHEQ) sin_movimientos <= bloqueado;
  end
`endif

endmodule

// File: tb/tb_mover_tablero.sv
module tb_mover_tablero;
  import tablero_pkg::*;

`ifdef MOVER_FIN_JUEGO_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = N;
`endif
  localparam int MW = N * N * TILE_W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    direccion = 2'b00;
  logic [MW-1:0] matriz_entrada = '0;
  logic          busy, done, movido;
  logic [MW-1:0] matriz_resultante;
  logic [TILE_W-1:0] puntos;
`ifdef MOVER_FIN_JUEGO_EN
  logic          sin_movimientos;
`endif

  mover_tablero dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .direccion         (direccion),
    .matriz_entrada    (matriz_entrada),
    .busy              (busy),
    .done              (done),
    .matriz_resultante (matriz_resultante),
    .movido            (movido),
    .puntos            (puntos)
`ifdef MOVER_FIN_JUEGO_EN
    ,
    .sin_movimientos   (sin_movimientos)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0]     mat;
    logic [TILE_W-1:0] pts;
    logic              mov;
    logic              sin;
  } esperado_t;

  esperado_t cola[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [MW-1:0] empaquetar(input tablero_t b);
    logic [MW-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        v[(r*N + c)*TILE_W +: TILE_W] = b[r][c];
    return v;
  endfunction

  task automatic chk(input string nombre, input logic [MW-1:0] act, input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nombre, act, req);
    end
  endtask

  // Monitor: every done pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (cola.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        esperado_t e;
        e = cola.pop_front();
        chk("matriz", matriz_resultante, e.mat);
        chk("puntos", MW'(puntos), MW'(e.pts));
        chk("movido", MW'(movido), MW'(e.mov));
`ifdef MOVER_FIN_JUEGO_EN
        chk("sin_movimientos", MW'(sin_movimientos), MW'(e.sin));
`endif
      end
    end
  end

  task automatic esperar_done(input int ya);
    int n;
    n = ya;
    while (!done && n < LAT + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latencia", MW'(n), MW'(LAT));
  endtask

  task automatic mover(input tablero_t b, input logic [1:0] d, input tablero_t eb,
                       input int pts, input logic mov, input logic sin);
    esperado_t e;
    @(negedge clk);
    matriz_entrada = empaquetar(b);
    direccion = d;
    start = 1'b1;
    e.mat = empaquetar(eb); e.pts = TILE_W'(pts); e.mov = mov; e.sin = sin;
    cola.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_tras_start", MW'(busy), MW'(1));
    esperar_done(0);
  endtask

  tablero_t b1, e1, b2, e2, b3, e3u, e3d, b4, b5, cero;

  initial begin
    b1  = '{'{0,2,2,0}, '{0,4,2,2}, '{2,2,4,0}, '{4,2,2,4}};
    e1  = '{'{4,0,0,0}, '{4,4,0,0}, '{4,4,0,0}, '{4,4,4,0}};
    b2  = '{'{2,2,2,2}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    e2  = '{'{0,0,4,4}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    b3  = '{'{2,0,0,0}, '{0,0,0,0}, '{2,0,0,0}, '{4,0,0,0}};
    e3u = '{'{4,0,0,0}, '{4,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    e3d = '{'{0,0,0,0}, '{0,0,0,0}, '{4,0,0,0}, '{4,0,0,0}};
    b4  = '{'{2,4,8,16}, '{4,8,16,2}, '{8,16,2,4}, '{16,2,4,8}};
    b5  = '{'{32'h8000_0000, 32'h8000_0000, 0, 0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
    cero = '{default: '0};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", MW'(busy), MW'(0));
    chk("reset_done", MW'(done), MW'(0));
    chk("reset_puntos", MW'(puntos), MW'(0));
    chk("reset_movido", MW'(movido), MW'(0));
    chk("reset_matriz", matriz_resultante, '0);
`ifdef MOVER_FIN_JUEGO_EN
    chk("reset_sin_mov", MW'(sin_movimientos), MW'(0));
`endif

    mover(b1, 2'b00, e1, 16, 1'b1, 1'b0);
    mover(b2, 2'b01, e2, 8, 1'b1, 1'b0);
    mover(b3, 2'b10, e3u, 4, 1'b1, 1'b0);
    mover(b3, 2'b11, e3d, 4, 1'b1, 1'b0);
    mover(b4, 2'b00, b4, 0, 1'b0, 1'b1);
    mover(b5, 2'b00, cero, 0, 1'b1, 1'b0);

    // Start pulse while busy must not disturb the move in flight.
    repeat (3) @(posedge clk);
    begin
      esperado_t e;
      @(negedge clk);
      matriz_entrada = empaquetar(b1);
      direccion = 2'b00;
      start = 1'b1;
      e.mat = empaquetar(e1); e.pts = 16; e.mov = 1'b1; e.sin = 1'b0;
      cola.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      matriz_entrada = empaquetar(b2);
      direccion = 2'b01;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      esperar_done(1);
    end
    repeat (LAT + 4) @(posedge clk);

    // Reset mid-move aborts without a done.
    @(negedge clk);
    matriz_entrada = empaquetar(b2);
    direccion = 2'b01;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", MW'(busy), MW'(0));
    chk("abort_done", MW'(done), MW'(0));
    chk("abort_puntos", MW'(puntos), MW'(0));
    chk("abort_movido", MW'(movido), MW'(0));
    chk("abort_matriz", matriz_resultante, '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1;
    chk("cola_vacia", MW'(cola.size()), MW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
